// File: rtl/alu_result_commit.sv
// Write-back stage of the ALU datapath: buffers finished results in a 2-entry
// FIFO, commits them through one register-file write port and holds the flags register.
module alu_result_commit #(
  parameter int INOUT_WIDTH = 8,
  parameter int FLAGS_WIDTH = 4,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                   master_clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INOUT_WIDTH-1:0] in_out_lo,
  input  logic [INOUT_WIDTH-1:0] in_out_hi,
  input  logic [FLAGS_WIDTH-1:0] in_flags,
  input  logic [ADDR_WIDTH-1:0]  in_dest,
  input  logic                   in_is_pair,
  input  logic                   in_wr_reg,
  input  logic                   in_wr_flags,
  output logic                   rf_we,
  output logic [ADDR_WIDTH-1:0]  rf_waddr,
  output logic [INOUT_WIDTH-1:0] rf_wdata,
  output logic [FLAGS_WIDTH-1:0] flags_out,
  output logic                   busy
);

  typedef struct packed {
    logic [INOUT_WIDTH-1:0] lo;
    logic [INOUT_WIDTH-1:0] hi;
    logic [FLAGS_WIDTH-1:0] flags;
    logic [ADDR_WIDTH-1:0]  dest;
    logic                   is_pair;
    logic                   wr_reg;
    logic                   wr_flags;
  } entry_t;

  typedef enum logic {LO, HI} state_e;

  entry_t                 fifo_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             count_q, count_d;
  state_e                 state_q, state_d;
  logic [FLAGS_WIDTH-1:0] flags_q, flags_d;

  entry_t head;
  logic   push, pop, we_raw;

  // No push-through-pop: a full FIFO refuses input even in a cycle that pops.
  assign in_ready = !reset && (count_q != 2'd2);
  assign push     = in_valid && in_ready;
  assign head     = fifo_q[rd_ptr_q];
  assign busy     = (count_q != 2'd0);
  assign flags_out = flags_q;
  assign rf_we    = we_raw && !reset;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    we_raw   = 1'b0;
    rf_waddr = head.dest;
    rf_wdata = head.lo;
    pop      = 1'b0;
    state_d  = state_q;
    flags_d  = flags_q;
    unique case (state_q)
      LO: begin
        if (count_q != 2'd0) begin
          we_raw = head.wr_reg;
          if (head.wr_flags) flags_d = head.flags;
          if (head.is_pair && head.wr_reg) state_d = HI;
          else                             pop     = 1'b1;
        end
      end
      HI: begin
        // High byte of a pair lands in the next register, wrapping at the top.
        we_raw   = 1'b1;
        rf_waddr = head.dest + ADDR_WIDTH'(1);
        rf_wdata = head.hi;
        pop      = 1'b1;
        state_d  = LO;
      end
      default: state_d = LO;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (!push && pop) count_d = count_q - 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      state_q  <= LO;
      flags_q  <= '0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      flags_q <= flags_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are live.
  always_ff @(posedge master_clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{lo: in_out_lo, hi: in_out_hi, flags: in_flags,
                            dest: in_dest, is_pair: in_is_pair,
                            wr_reg: in_wr_reg, wr_flags: in_wr_flags};
    end
  end

endmodule

// File: tb/tb_alu_result_commit.sv
// Scoreboard bench for alu_result_commit: expected register writes are queued
// on accept and matched against rf_we/rf_waddr/rf_wdata sampled on the falling edge.
module tb_alu_result_commit;

  logic       master_clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_out_lo, in_out_hi;
  logic [3:0] in_flags;
  logic [3:0] in_dest;
  logic       in_is_pair, in_wr_reg, in_wr_flags;
  logic       rf_we;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [3:0] flags_out;
  logic       busy;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_err  = 0;
  int  stalls = 0;

  always #5 master_clk = ~master_clk;

  alu_result_commit dut (
    .master_clk (master_clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_out_lo  (in_out_lo),
    .in_out_hi  (in_out_hi),
    .in_flags   (in_flags),
    .in_dest    (in_dest),
    .in_is_pair (in_is_pair),
    .in_wr_reg  (in_wr_reg),
    .in_wr_flags(in_wr_flags),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .flags_out  (flags_out),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every write the DUT makes must be the oldest outstanding expected write.
  always @(negedge master_clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {20'd0, rf_waddr, rf_wdata}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(rf_waddr), 32'(e.addr));
        check("wr_data", 32'(rf_wdata), 32'(e.data));
      end
    end
  end

  // Present one result and hold it until accepted; queue its expected writes.
  task automatic send(input logic [7:0] lo, input logic [7:0] hi, input logic [3:0] fl,
                      input logic [3:0] dest, input logic pair, input logic wr_reg,
                      input logic wr_flags, input logic expect_hi = 1'b1);
    int budget;
    @(negedge master_clk);
    in_valid = 1'b1; in_out_lo = lo; in_out_hi = hi; in_flags = fl;
    in_dest = dest; in_is_pair = pair; in_wr_reg = wr_reg; in_wr_flags = wr_flags;
    budget = 200;
    while (!in_ready && budget > 0) begin
      stalls++;
      budget--;
      @(negedge master_clk);
    end
    if (!in_ready) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      if (wr_reg) exp_q.push_back('{addr: dest, data: lo});
      if (wr_reg && pair && expect_hi) exp_q.push_back('{addr: dest + 4'd1, data: hi});
      @(posedge master_clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 100;
    while ((busy || exp_q.size() != 0) && budget > 0) begin
      budget--;
      @(negedge master_clk);
    end
    check(tag, {31'd0, busy}, 32'd0);
    check({tag, "_q"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_out_lo = '0; in_out_hi = '0; in_flags = '0;
    in_dest = '0; in_is_pair = 1'b0; in_wr_reg = 1'b0; in_wr_flags = 1'b0;
    repeat (3) @(posedge master_clk);
    @(negedge master_clk);
    check("rst_ready",  32'(in_ready),  32'd0);
    check("rst_we",     32'(rf_we),     32'd0);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_flags",  32'(flags_out), 32'd0);
    @(posedge master_clk); #1 reset = 1'b0;
    @(negedge master_clk);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Single 8-bit result with flags.
    send(8'hA5, 8'h00, 4'b0101, 4'd3, 1'b0, 1'b1, 1'b1);
    @(negedge master_clk);
    check("s_we",        32'(rf_we),     32'd1);
    check("s_flags_pre", 32'(flags_out), 32'd0);
    @(negedge master_clk);
    check("s_we_off",    32'(rf_we),     32'd0);
    check("s_flags",     32'(flags_out), 32'b0101);
    check("s_busy",      32'(busy),      32'd0);

    // Pair result, flags untouched.
    send(8'h34, 8'h12, 4'b1111, 4'd6, 1'b1, 1'b1, 1'b0);
    @(negedge master_clk);
    check("p_busy1", 32'(busy), 32'd1);
    @(negedge master_clk);
    check("p_busy2", 32'(busy), 32'd1);
    check("p_hi_addr", 32'(rf_waddr), 32'd7);
    @(negedge master_clk);
    check("p_busy3", 32'(busy), 32'd0);
    check("p_flags", 32'(flags_out), 32'b0101);

    // Flags-only (cmp) and pair with wr_reg=0: one cycle each, no writes.
    send(8'h77, 8'h00, 4'b1000, 4'd1, 1'b0, 1'b0, 1'b1);
    @(negedge master_clk);
    check("c_busy1", 32'(busy), 32'd1);
    @(negedge master_clk);
    check("c_busy2", 32'(busy), 32'd0);
    check("c_flags", 32'(flags_out), 32'b1000);
    send(8'h55, 8'h66, 4'b0110, 4'd9, 1'b1, 1'b0, 1'b1);
    @(negedge master_clk);
    @(negedge master_clk);
    check("pc_busy",  32'(busy), 32'd0);
    check("pc_flags", 32'(flags_out), 32'b0110);

    // Backpressure: four back-to-back pairs.
    stalls = 0;
    send(8'h01, 8'h81, 4'd0, 4'd0,  1'b1, 1'b1, 1'b0);
    send(8'h02, 8'h82, 4'd0, 4'd2,  1'b1, 1'b1, 1'b0);
    send(8'h03, 8'h83, 4'd0, 4'd9,  1'b1, 1'b1, 1'b0);
    send(8'h04, 8'h84, 4'd0, 4'hC,  1'b1, 1'b1, 1'b0);
    check("bp_stalled", 32'(stalls != 0), 32'd1);
    drain("bp_drain");

    // Address wrap on the high byte.
    send(8'hF0, 8'h0F, 4'd0, 4'hF, 1'b1, 1'b1, 1'b0);
    drain("wrap_drain");

    // Reset during the HI cycle abandons the high byte.
    send(8'hBB, 8'hAA, 4'b0011, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge master_clk);
    @(posedge master_clk); #1 reset = 1'b1;
    @(negedge master_clk);
    check("mr_we",    32'(rf_we),     32'd0);
    check("mr_ready", 32'(in_ready),  32'd0);
    check("mr_flags", 32'(flags_out), 32'b0011);
    @(posedge master_clk); #1 reset = 1'b0;
    @(negedge master_clk);
    check("ar_we",    32'(rf_we),     32'd0);
    check("ar_busy",  32'(busy),      32'd0);
    check("ar_flags", 32'(flags_out), 32'd0);
    check("ar_ready", 32'(in_ready),  32'd1);
    repeat (3) @(negedge master_clk);

    // Recovery after reset.
    send(8'h5A, 8'h00, 4'b0001, 4'd4, 1'b0, 1'b1, 1'b1);
    drain("rec_drain");
    check("rec_flags", 32'(flags_out), 32'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_commit.md
# alu_result_commit

Write-back end of the ALU datapath: accepts finished ALU results (`out_lo`, `out_hi`, `proc_flags_out`) over a valid/ready handshake and buffers them in a 2-entry FIFO. It commits them to the register file through a single write port and holds the architectural processor-flags register, whose value feeds back to the ALU's `proc_flags_in`. It is the consumer of the operand/opcode driver that presents ALU inputs. 16-bit pair results are serialised into two register writes.

## Interface
- `INOUT_WIDTH`, 8, ALU data width (matches `alu_inout_width`)
- `FLAGS_WIDTH`, 4, processor flags width (matches `proc_flags_width`)
- `ADDR_WIDTH`, 4, register-file address width
- `master_clk`  in  1  sole clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  result presented this cycle
- `in_ready`  out  1  block can accept a result
- `in_out_lo`  in  INOUT_WIDTH  ALU `out_lo`
- `in_out_hi`  in  INOUT_WIDTH  ALU `out_hi`; used only when `in_is_pair`=1
- `in_flags`  in  FLAGS_WIDTH  ALU `proc_flags_out`
- `in_dest`  in  ADDR_WIDTH  destination register for the low byte
- `in_is_pair`  in  1  result comes from a 16-bit op category and writes two registers
- `in_wr_reg`  in  1  0 = flags-only result (e.g. `alu_op_cmp`), no register write
- `in_wr_flags`  in  1  1 = update the flags register
- `rf_we`  out  1  register-file write enable
- `rf_waddr`  out  ADDR_WIDTH  write address
- `rf_wdata`  out  INOUT_WIDTH  write data
- `flags_out`  out  FLAGS_WIDTH  committed flags; drives ALU `proc_flags_in`
- `busy`  out  1  FIFO non-empty

## Operation
- Acceptance: a result is accepted when `in_valid && in_ready` at a posedge and is pushed into the FIFO tail. `in_ready = !reset && (count != 2)`. There is no push-through-pop when the FIFO is full: when count=2, `in_ready`=0 even if a pop occurs in that cycle.
- FIFO: 2 entries. Each entry holds {lo, hi, flags, dest, is_pair, wr_reg, wr_flags}. `count` ranges 0..2. A simultaneous push and pop leaves `count` unchanged.
- Commit FSM, states `LO` and `HI`. `LO` is the reset state.
  - `LO`, FIFO empty: `rf_we`=0, FSM stays in `LO`.
  - `LO`, head present: `rf_we = head.wr_reg`, `rf_waddr = head.dest`, `rf_wdata = head.lo`. If `head.wr_flags`=1, flags register ← `head.flags` at the edge.
    - If `head.is_pair && head.wr_reg`: go to `HI`; the head is not popped.
    - Otherwise: pop the head and stay in `LO`.
  - `HI`: `rf_we`=1, `rf_waddr = head.dest + 1` (modulo 2^ADDR_WIDTH, so 4'hF wraps to 4'h0), `rf_wdata = head.hi`. Pop the head and return to `LO`. Flags are not written again.
- `is_pair` with `wr_reg`=0 is treated as flags-only: one cycle, no write.
- `rf_we`, `rf_waddr`, `rf_wdata` are combinational from FSM state and the FIFO head. `flags_out` is a register.
- `busy = (count != 0)`.
- Reset (any cycle, including while in `HI`):
  - FIFO cleared, count=0, FSM → `LO`, `flags_out` = 0.
  - Outputs during and after reset until the next accept: `rf_we`=0, `in_ready`=0 while `reset`=1.
  - A partially committed pair is abandoned; its high byte is never written.

## Timing
- Accept at edge N (FIFO empty, FSM in `LO`): low write is visible in cycle N+1; for a pair, the high write follows in N+2.
- Flags written at the end of the `LO` cycle are visible on `flags_out` one cycle after that write (N+2 for the example above).
- Throughput: 1 result/cycle for 8-bit and flags-only results; 1 per 2 cycles for pairs.
- Backpressure: with continuous pairs, `in_ready` falls after 2 accepts and re-rises after the first pair fully commits.
- `in_*` inputs are sampled only on accept; they need not be held afterwards.

## Test plan
- Single 8-bit result: lo=8'hA5, dest=3, wr_reg=1, wr_flags=1, flags=4'b0101 → `rf_we`=1, addr 3, data A5 for exactly one cycle; `flags_out`=0101 the cycle after.
- Pair result: hi=8'h12, lo=8'h34, dest=6 → cycle 1: addr 6 data 34; cycle 2: addr 7 data 12. `busy` drops after cycle 2.
- Flags-only result (cmp), flags=4'b1000 → `rf_we` never asserted; `flags_out`=1000; FIFO empties in 1 cycle.
- Backpressure: hold `in_valid`=1 with 4 consecutive pair results → exactly 8 writes in order with correct addresses; `in_ready` toggles as count hits 2; no result lost or duplicated.
- Wrap: pair with dest=4'hF → writes to F then 0.
- Reset mid-pair: assert `reset` in the `HI` cycle → no high write; the next cycle shows `rf_we`=0, `busy`=0, `flags_out`=0, and `in_ready`=1 once reset is released.
